instr_mem_loader: RTL and testbench

// - Write side of the 16-bit instruction memory. Fills the writable instruction RAM at power-up from an 8-bit byte stream.
// - Holds the one-cycle core in reset (cpu_hold) while loading, then releases it with PC=0 content in place.
// - The fetch path reads 8-bit address -> 16-bit word. This block produces that content one word per write.

---
 rtl/instr_pkg.sv | 27 ++
 rtl/instr_mem_loader.sv | 157 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// ============================================================================
// Module : instr_pkg
// Brief  : Shared instruction-memory types for the loader, core and RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_pkg;

    localparam int INSTR_W = 16;
    localparam int IADDR_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        WRITE = 3'd4,
        CHECK = 3'd5,
        DONE  = 3'd6
    } ld_state_t;

    typedef logic [INSTR_W-1:0] instr_t;

endpackage

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// ============================================================================
// Module : instr_mem_loader
// Brief  : Fills the instruction RAM from a byte stream while holding the core
//          in reset. Optional trailing XOR checksum: INSTR_LOADER_CHECKSUM_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_mem_loader
    import instr_pkg::*;
#(
    parameter int ADDR_W = IADDR_W,
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    ld_state_t         r_state;
    ld_state_t         w_next;
    logic [ADDR_W-1:0] r_n;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_hi;
    logic [7:0]        r_lo;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_cnt_inc;

    assign w_xfer    = byte_valid & byte_ready;
    assign w_cnt_inc = r_count + ADDR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = COUNT;
            end
            COUNT: begin
                byte_ready = 1'b1;
                if (w_xfer) w_next = HI;
            end
            HI: begin
                byte_ready = 1'b1;
                if (w_xfer) w_next = LO;
            end
            LO: begin
                byte_ready = 1'b1;
                if (w_xfer) w_next = WRITE;
            end
            WRITE: begin
                wr_en = 1'b1;
                // N of 0 loads the full depth: the count wraps back to 0.
                if (w_cnt_inc == r_n) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    w_next = CHECK;
`else
                    w_next = DONE;
`endif
                end else begin
                    w_next = HI;
                end
            end
            CHECK: begin
                byte_ready = 1'b1;
                if (w_xfer) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n     <= '0;
            r_count <= '0;
            r_addr  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_count <= '0;
                        r_addr  <= '0;
                    end
                end
                COUNT: if (w_xfer) r_n  <= ADDR_W'(byte_data);
                HI:    if (w_xfer) r_hi <= byte_data;
                LO:    if (w_xfer) r_lo <= byte_data;
                WRITE: begin
                    r_addr  <= r_addr + ADDR_W'(1);
                    r_count <= w_cnt_inc;
                end
                default: ;
            endcase
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] r_xor;
    logic       r_err;

    // Running XOR covers payload bytes only, never the word count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xor <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_xor <= '0;
                r_err <= 1'b0;
            end else if ((r_state == HI || r_state == LO) && w_xfer) begin
                r_xor <= r_xor ^ byte_data;
            end else if (r_state == CHECK && w_xfer) begin
                r_err <= (byte_data != r_xor);
            end
        end
    end

    assign error = r_err;
`else
    assign error = 1'b0;
`endif

    assign wr_addr  = r_addr;
    assign wr_data  = DATA_W'({r_hi, r_lo});
    assign busy     = (r_state != IDLE);
    assign cpu_hold = busy;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ============================================================================
// Module : tb_instr_mem_loader
// Brief  : Self-checking bench for instr_mem_loader (table, corner and random
//          loads compared against a frame-level reference model).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    instr_mem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t mon_q[$];
    int  ready_viol = 0;
    int  hold_viol  = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                mon_q.push_back({wr_addr, wr_data});
                if (byte_ready) ready_viol++;
            end
            if (cpu_hold !== busy) hold_viol++;
        end
    end

    logic [7:0] frame_q[$];

    function automatic logic [7:0] frame_xor();
        logic [7:0] x = 8'h00;
        for (int i = 1; i < frame_q.size(); i++) x ^= frame_q[i];
        return x;
    endfunction

    // mode: 0 valid always, 1 valid toggles, 2 valid random
    task automatic run_load(input int mode, input bit startp, input bit corrupt);
        logic [7:0] tx[$];
        int   n, base, rv0, hv0, idx, cyc;
        bit   fin, v;
        logic exp_err;
        tx      = frame_q;
        exp_err = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        tx.push_back(corrupt ? (frame_xor() ^ 8'h88) : frame_xor());
        exp_err = corrupt;
`endif
        n    = (frame_q[0] == 8'h00) ? 256 : int'(frame_q[0]);
        base = mon_q.size();
        rv0  = ready_viol;
        hv0  = hold_viol;
        @(negedge clk);
        start      = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("error_cleared", error, 0);
        idx = 0;
        cyc = 0;
        fin = 1'b0;
        while (!fin && cyc < 4000) begin
            if (done) begin
                fin        = 1'b1;
                byte_valid = 1'b0;
                start      = 1'b0;
            end else begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (cyc % 2 == 0);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                if (idx < tx.size()) begin
                    byte_valid = v;
                    byte_data  = tx[idx];
                    if (v && byte_ready) idx++;
                end else begin
                    byte_valid = 1'b0;
                end
                start = startp && ($urandom_range(0, 3) == 0);
                @(negedge clk);
                cyc++;
            end
        end
        check("load_timeout", fin, 1);
        check("error_at_done", error, exp_err);
        check("bytes_used", idx, tx.size());
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_fall", busy, 0);
        check("error_sticky", error, exp_err);
        check("write_count", mon_q.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < mon_q.size())
                check("write", mon_q[base + i], {8'(i), frame_q[1 + 2 * i], frame_q[2 + 2 * i]});
        end
        check("ready_in_write", ready_viol - rv0, 0);
        check("hold_eq_busy", hold_viol - hv0, 0);
    endtask

    typedef struct {
        logic [63:0] bytes;
        int          len;
        int          mode;
        bit          startp;
        int          exp_writes;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        tbl[0] = '{64'h03_48_10_4A_12_4C_14_00, 7, 0, 1'b0, 3, 16'h4810, 16'h4C14};
        tbl[1] = '{64'h03_48_10_4A_12_4C_14_00, 7, 1, 1'b0, 3, 16'h4810, 16'h4C14};
        tbl[2] = '{64'h03_48_10_4A_12_4C_14_00, 7, 0, 1'b1, 3, 16'h4810, 16'h4C14};
        tbl[3] = '{64'h01_50_0A_00_00_00_00_00, 3, 2, 1'b0, 1, 16'h500A, 16'h500A};
        tbl[4] = '{64'h02_DE_AD_BE_EF_00_00_00, 5, 2, 1'b1, 2, 16'hDEAD, 16'hBEEF};

        // reset held together with start: reset wins
        reset      = 1'b1;
        start      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {byte_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, error}, 0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_after_reset", busy, 0);

        for (int t = 0; t < 5; t++) begin
            frame_q.delete();
            for (int i = 0; i < tbl[t].len; i++) frame_q.push_back(tbl[t].bytes[63 - 8 * i -: 8]);
            base = mon_q.size();
            run_load(tbl[t].mode, tbl[t].startp, 1'b0);
            check("tbl_writes", mon_q.size() - base, tbl[t].exp_writes);
            if (mon_q.size() > base) begin
                check("tbl_first", mon_q[base].d, tbl[t].exp_first);
                check("tbl_last", mon_q[mon_q.size() - 1].d, tbl[t].exp_last);
            end
        end

        // reset after the hi byte of word 1
        begin
            int idx = 0;
            int cyc = 0;
            frame_q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
            base = mon_q.size();
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (idx < 4 && cyc < 50) begin
                byte_valid = 1'b1;
                byte_data  = frame_q[idx];
                if (byte_ready) idx++;
                @(negedge clk);
                cyc++;
            end
            byte_valid = 1'b0;
            #2 reset = 1'b1;
            #1 check("midload_reset_outputs", {byte_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, error}, 0);
            @(negedge clk);
            reset = 1'b0;
            check("midload_writes", mon_q.size() - base, 1);
            if (mon_q.size() > base) check("midload_word0", mon_q[base], {8'h00, 16'h1122});
            frame_q = '{8'h01, 8'h50, 8'h0A};
            base = mon_q.size();
            run_load(0, 1'b0, 1'b0);
            if (mon_q.size() > base) check("reload_addr0", mon_q[base], {8'h00, 16'h500A});
        end

        // full depth load, word value = address
        frame_q.delete();
        frame_q.push_back(8'h00);
        for (int i = 0; i < 256; i++) begin
            frame_q.push_back(8'h00);
            frame_q.push_back(8'(i));
        end
        base = mon_q.size();
        run_load(0, 1'b0, 1'b0);
        if (mon_q.size() >= base + 256) check("full_last", mon_q[base + 255], {8'hFF, 16'h00FF});
        check("full_addr_wrap", wr_addr, 0);

`ifdef INSTR_LOADER_CHECKSUM_EN
        frame_q = '{8'h01, 8'h08, 8'h80};
        run_load(0, 1'b0, 1'b0);
        run_load(0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("error_held_idle", error, 1);
`endif

        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 8);
            frame_q.delete();
            frame_q.push_back(8'(n));
            for (int i = 0; i < 2 * n; i++) frame_q.push_back(8'($urandom));
            run_load($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
